// File: rtl/id_pkg.sv
// Shared definitions for the decode stage: ALU opcodes, instruction field
// positions, register-file geometry and the instruction decoder.
package id_pkg;

  localparam int REG_ADDR_W = 3;
  localparam int NUM_REGS   = 8;
  localparam int INSTR_W    = 16;
  localparam int OPC_W      = 4;
  localparam int IMM_W      = 5;

  // ALU opcodes understood by EX; everything above OP_SHR is illegal.
  localparam logic [OPC_W-1:0] OP_ADD = 4'd0;
  localparam logic [OPC_W-1:0] OP_SUB = 4'd1;
  localparam logic [OPC_W-1:0] OP_AND = 4'd2;
  localparam logic [OPC_W-1:0] OP_OR  = 4'd3;
  localparam logic [OPC_W-1:0] OP_XOR = 4'd4;
  localparam logic [OPC_W-1:0] OP_SLT = 4'd5;
  localparam logic [OPC_W-1:0] OP_SHL = 4'd6;
  localparam logic [OPC_W-1:0] OP_SHR = 4'd7;

  // Instruction field bit positions.
  localparam int OPC_HI  = 15;
  localparam int OPC_LO  = 12;
  localparam int RD_HI   = 11;
  localparam int RD_LO   = 9;
  localparam int RS1_HI  = 8;
  localparam int RS1_LO  = 6;
  localparam int USE_IMM = 5;
  localparam int IMM_HI  = 4;
  localparam int IMM_LO  = 0;
  localparam int RS2_HI  = 2;
  localparam int RS2_LO  = 0;

  typedef struct packed {
    logic [OPC_W-1:0]      opcode;
    logic [REG_ADDR_W-1:0] rd;
    logic [REG_ADDR_W-1:0] rs1;
    logic [REG_ADDR_W-1:0] rs2;
    logic                  use_imm;
    logic [IMM_W-1:0]      imm5;
    logic                  legal;
  } instr_t;

  // Split an instruction word into its fields; rs2 is meaningful only when
  // use_imm is clear, imm5 only when it is set.
  function automatic instr_t decode(input logic [INSTR_W-1:0] instr);
    instr_t d;
    d.opcode  = instr[OPC_HI:OPC_LO];
    d.rd      = instr[RD_HI:RD_LO];
    d.rs1     = instr[RS1_HI:RS1_LO];
    d.rs2     = instr[RS2_HI:RS2_LO];
    d.use_imm = instr[USE_IMM];
    d.imm5    = instr[IMM_HI:IMM_LO];
    d.legal   = (d.opcode <= OP_SHR);
    return d;
  endfunction

endpackage

// File: rtl/id_stage_if.sv
// Bundle of the fetch handshake, EX payload and WB writeback signals seen by
// the decode stage. slave = decode stage, master = its environment.
interface id_stage_if
  import id_pkg::*;
#(
  parameter int WIDTH = 8
);

  logic                  if_valid;
  logic [INSTR_W-1:0]    if_instr;
  logic                  if_ready;
  logic                  ex_valid;
  logic                  ex_ready;
  logic [WIDTH-1:0]      ex_a;
  logic [WIDTH-1:0]      ex_b;
  logic [OPC_W-1:0]      ex_opcode;
  logic [REG_ADDR_W-1:0] ex_rd;
  logic                  wb_en;
  logic [REG_ADDR_W-1:0] wb_rd;
  logic [WIDTH-1:0]      wb_data;
  logic                  illegal;

  modport master (
    output if_valid, if_instr, ex_ready, wb_en, wb_rd, wb_data,
    input  if_ready, ex_valid, ex_a, ex_b, ex_opcode, ex_rd, illegal
  );

  modport slave (
    input  if_valid, if_instr, ex_ready, wb_en, wb_rd, wb_data,
    output if_ready, ex_valid, ex_a, ex_b, ex_opcode, ex_rd, illegal
  );

endinterface

// File: rtl/id_regfile.sv
// 8 x WIDTH register file: two asynchronous read ports, one synchronous
// write port, R0 hardwired to zero, write-first bypass on both read ports.
module id_regfile
  import id_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [REG_ADDR_W-1:0] ra1,
  input  logic [REG_ADDR_W-1:0] ra2,
  output logic [WIDTH-1:0]      rd1,
  output logic [WIDTH-1:0]      rd2,
  input  logic                  we,
  input  logic [REG_ADDR_W-1:0] wa,
  input  logic [WIDTH-1:0]      wd
);

  logic [WIDTH-1:0] regs [NUM_REGS];
  logic             wr_act;

  assign wr_act = we && (wa != '0);

  // Register storage; writes to R0 are dropped.
  // NOTE: the array is cleared on reset because all registers must read 0
  // after reset, which rules out mapping it onto a non-resettable RAM; all
  // state here uses <= so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (wr_act) begin
      regs[wa] <= wd;
    end
  end

  // Read port 1: R0 is zero, a same-cycle write to the address wins.
  // NOTE: the output gets a value on every path before any condition, so no
  // latch can be inferred.
  always_comb begin
    rd1 = regs[ra1];
    if (ra1 == '0)                  rd1 = '0;
    else if (wr_act && (wa == ra1)) rd1 = wd;
  end

  // Read port 2: same rules as port 1.
  always_comb begin
    rd2 = regs[ra2];
    if (ra2 == '0)                  rd2 = '0;
    else if (wr_act && (wa == ra2)) rd2 = wd;
  end

endmodule

// File: rtl/id_stage.sv
// Decode stage: accepts instructions from fetch, checks the busy scoreboard
// for RAW/WAW hazards, reads operands and registers the payload for EX.
// WIDTH must be at least 5 so the zero-extended imm5 fits in operand B.
module id_stage
  import id_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input logic        clk,
  input logic        rst_n,
  id_stage_if.slave  bus
);

  instr_t                dec;
  logic [WIDTH-1:0]      rs1_val;
  logic [WIDTH-1:0]      rs2_val;
  logic [WIDTH-1:0]      opb;
  logic                  wb_act;
  logic                  hazard;
  logic                  xfer;
  logic                  issue;
  logic [NUM_REGS-1:0]   busy;
  logic [NUM_REGS-1:0]   busy_clr;
  logic [NUM_REGS-1:0]   busy_eff;
  logic [NUM_REGS-1:0]   busy_next;

  logic                  ex_valid_q;
  logic [WIDTH-1:0]      ex_a_q;
  logic [WIDTH-1:0]      ex_b_q;
  logic [OPC_W-1:0]      ex_opcode_q;
  logic [REG_ADDR_W-1:0] ex_rd_q;
  logic                  illegal_q;

  assign dec    = decode(bus.if_instr);
  assign wb_act = bus.wb_en && (bus.wb_rd != '0);

  // Busy bits released by this cycle's writeback count as already free.
  always_comb begin
    busy_clr = '0;
    if (wb_act) busy_clr[bus.wb_rd] = 1'b1;
  end

  assign busy_eff = busy & ~busy_clr;

  // Illegal opcodes never stall: they are consumed without touching state.
  assign hazard = dec.legal &&
                  (busy_eff[dec.rs1] ||
                   (!dec.use_imm && busy_eff[dec.rs2]) ||
                   busy_eff[dec.rd]);

  assign bus.if_ready = (!ex_valid_q || bus.ex_ready) && !hazard;
  assign xfer         = bus.if_valid && bus.if_ready;
  assign issue        = xfer && dec.legal;

  id_regfile #(.WIDTH(WIDTH)) u_rf (
    .clk   (clk),
    .rst_n (rst_n),
    .ra1   (dec.rs1),
    .ra2   (dec.rs2),
    .rd1   (rs1_val),
    .rd2   (rs2_val),
    .we    (bus.wb_en),
    .wa    (bus.wb_rd),
    .wd    (bus.wb_data)
  );

  assign opb = dec.use_imm ? WIDTH'(dec.imm5) : rs2_val;

  // Next scoreboard: writeback clear first, then the issuing rd is set, so a
  // same-cycle clear and set on one register leaves it busy.
  always_comb begin
    busy_next = busy_eff;
    if (issue && (dec.rd != '0)) busy_next[dec.rd] = 1'b1;
  end

  // Scoreboard register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) busy <= '0;
    else        busy <= busy_next;
  end

  // EX payload register and illegal-opcode pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid_q  <= 1'b0;
      ex_a_q      <= '0;
      ex_b_q      <= '0;
      ex_opcode_q <= '0;
      ex_rd_q     <= '0;
      illegal_q   <= 1'b0;
    end else begin
      illegal_q <= xfer && !dec.legal;
      if (issue) begin
        ex_valid_q  <= 1'b1;
        ex_a_q      <= rs1_val;
        ex_b_q      <= opb;
        ex_opcode_q <= dec.opcode;
        ex_rd_q     <= dec.rd;
      end else if (bus.ex_ready) begin
        ex_valid_q <= 1'b0;
      end
    end
  end

  assign bus.ex_valid  = ex_valid_q;
  assign bus.ex_a      = ex_a_q;
  assign bus.ex_b      = ex_b_q;
  assign bus.ex_opcode = ex_opcode_q;
  assign bus.ex_rd     = ex_rd_q;
  assign bus.illegal   = illegal_q;

endmodule

// File: tb/tb_id_stage.sv
// Directed bench for id_stage: stimulus pushes hand-computed EX payloads into
// a queue; a monitor pops and compares each payload as EX consumes it.
module tb_id_stage;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [3:0] op;
    logic [2:0] rd;
  } exp_t;

  logic clk;
  logic rst_n;
  int   n_vec  = 0;
  int   n_miss = 0;
  exp_t exp_q[$];

  id_stage_if #(.WIDTH(8)) bus ();

  id_stage #(.WIDTH(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Present instr until accepted (bounded), optionally queueing its expected payload.
  task automatic issue(input logic [15:0] instr, input bit push,
                       input logic [7:0] ea, input logic [7:0] eb,
                       input logic [3:0] eop, input logic [2:0] erd,
                       output int waits);
    exp_t e;
    if (push) begin
      e.a = ea; e.b = eb; e.op = eop; e.rd = erd;
      exp_q.push_back(e);
    end
    bus.if_valid = 1'b1;
    bus.if_instr = instr;
    waits = 0;
    forever begin
      @(negedge clk);
      if (bus.if_ready) break;
      waits++;
      if (waits > 20) begin
        n_vec++;
        n_miss++;
        $display("FAIL issue_timeout: instr %04h never accepted", instr);
        break;
      end
    end
    @(posedge clk);
    #1;
    bus.if_valid = 1'b0;
  endtask

  task automatic wb(input logic [2:0] rd, input logic [7:0] data);
    bus.wb_en   = 1'b1;
    bus.wb_rd   = rd;
    bus.wb_data = data;
    @(posedge clk);
    #1;
    bus.wb_en = 1'b0;
  endtask

  // Monitor: every payload EX consumes must match the head of the queue.
  always @(negedge clk) begin
    if (rst_n && bus.ex_valid && bus.ex_ready) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_miss++;
        $display("FAIL unexpected_payload: a=%0h b=%0h op=%0h rd=%0h",
                 bus.ex_a, bus.ex_b, bus.ex_opcode, bus.ex_rd);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("ex_a", 32'(bus.ex_a), 32'(e.a));
        check("ex_b", 32'(bus.ex_b), 32'(e.b));
        check("ex_opcode", 32'(bus.ex_opcode), 32'(e.op));
        check("ex_rd", 32'(bus.ex_rd), 32'(e.rd));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    bus.if_valid = 1'b0;
    bus.if_instr = '0;
    bus.ex_ready = 1'b1;
    bus.wb_en    = 1'b0;
    bus.wb_rd    = '0;
    bus.wb_data  = '0;
    rst_n        = 1'b0;

    // Reset state.
    #2;
    check("rst_ex_valid", 32'(bus.ex_valid), 0);
    check("rst_ex_a", 32'(bus.ex_a), 0);
    check("rst_ex_b", 32'(bus.ex_b), 0);
    check("rst_illegal", 32'(bus.illegal), 0);
    check("rst_busy", 32'(dut.busy), 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // R1=5, R2=3, then ADD r3 = r1 + r2.
    wb(3'd1, 8'd5);
    wb(3'd2, 8'd3);
    issue(16'h0642, 1, 8'd5, 8'd3, 4'd0, 3'd3, w);
    check("add_busy", 32'(dut.busy), 32'h08);

    // SUB r4 = r3 - r1 stalls on busy r3 until the writeback of r3.
    exp_q.push_back('{a: 8'd8, b: 8'd5, op: 4'd1, rd: 3'd4});
    bus.if_valid = 1'b1;
    bus.if_instr = 16'h18C1;
    @(negedge clk);
    check("raw_stall_0", 32'(bus.if_ready), 0);
    @(posedge clk);
    #1;
    @(negedge clk);
    check("raw_stall_1", 32'(bus.if_ready), 0);
    @(posedge clk);
    #1;
    bus.wb_en   = 1'b1;
    bus.wb_rd   = 3'd3;
    bus.wb_data = 8'd8;
    @(negedge clk);
    check("raw_release", 32'(bus.if_ready), 1);
    @(posedge clk);
    #1;
    bus.if_valid = 1'b0;
    bus.wb_en    = 1'b0;
    check("sub_busy", 32'(dut.busy), 32'h10);

    // ADD r4 while r4 busy, with same-cycle writeback of r4: passes, bit stays set.
    bus.wb_en   = 1'b1;
    bus.wb_rd   = 3'd4;
    bus.wb_data = 8'd7;
    issue(16'h0800, 1, 8'd0, 8'd0, 4'd0, 3'd4, w);
    bus.wb_en = 1'b0;
    check("waw_same_cycle_waits", 32'(w), 0);
    check("waw_busy_kept", 32'(dut.busy), 32'h10);
    wb(3'd4, 8'd7);
    check("wb_clear_busy", 32'(dut.busy), 32'h00);

    // OR r5 = r1|r2 issued, then EX stalls for 3 cycles with AND r6 waiting.
    issue(16'h3A42, 1, 8'd5, 8'd3, 4'd3, 3'd5, w);
    bus.ex_ready = 1'b0;
    exp_q.push_back('{a: 8'd3, b: 8'h0A, op: 4'd2, rd: 3'd6});
    bus.if_valid = 1'b1;
    bus.if_instr = 16'h2CAA;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("hold_ex_valid", 32'(bus.ex_valid), 1);
      check("hold_ex_a", 32'(bus.ex_a), 5);
      check("hold_ex_b", 32'(bus.ex_b), 3);
      check("hold_ex_rd", 32'(bus.ex_rd), 5);
      check("hold_if_ready", 32'(bus.if_ready), 0);
      @(posedge clk);
      #1;
    end
    bus.ex_ready = 1'b1;
    @(negedge clk);
    check("hold_release_if_ready", 32'(bus.if_ready), 1);
    @(posedge clk);
    #1;
    bus.if_valid = 1'b0;

    // Illegal opcode 0xA (rd=r5 busy, ignored): consumed, pulse, no issue.
    issue(16'hAA00, 0, 8'd0, 8'd0, 4'd0, 3'd0, w);
    check("illegal_no_stall", 32'(w), 0);
    check("illegal_pulse", 32'(bus.illegal), 1);
    check("illegal_ex_valid", 32'(bus.ex_valid), 0);
    check("illegal_busy", 32'(dut.busy), 32'h60);
    @(posedge clk);
    #1;
    check("illegal_one_cycle", 32'(bus.illegal), 0);

    // XOR r0 = r0 ^ 0x1F; then SLT r7 reading r0 must not stall.
    issue(16'h403F, 1, 8'd0, 8'h1F, 4'd4, 3'd0, w);
    check("r0_busy_never_set", 32'(dut.busy), 32'h60);
    issue(16'h5E00, 1, 8'd0, 8'd0, 4'd5, 3'd7, w);
    check("r0_read_no_stall", 32'(w), 0);

    // Illegal right behind a legal payload with ex_ready high drains ex_valid.
    issue(16'hF000, 0, 8'd0, 8'd0, 4'd0, 3'd0, w);
    check("illegal2_pulse", 32'(bus.illegal), 1);
    check("illegal2_ex_valid", 32'(bus.ex_valid), 0);

    // SHR r1 = r2 >> r2 with same-cycle writeback r2=0x9C: both operands bypass.
    bus.wb_en   = 1'b1;
    bus.wb_rd   = 3'd2;
    bus.wb_data = 8'h9C;
    issue(16'h7282, 1, 8'h9C, 8'h9C, 4'd7, 3'd1, w);
    bus.wb_en = 1'b0;
    check("shr_busy", 32'(dut.busy), 32'hE2);
    @(posedge clk);
    #1;

    // SHL r2 held in EX, then asynchronous reset mid-cycle.
    bus.ex_ready = 1'b0;
    issue(16'h6423, 0, 8'd0, 8'd0, 4'd0, 3'd0, w);
    check("shl_ex_valid", 32'(bus.ex_valid), 1);
    check("shl_ex_b", 32'(bus.ex_b), 3);
    check("shl_ex_opcode", 32'(bus.ex_opcode), 6);
    check("shl_busy", 32'(dut.busy), 32'hE6);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_ex_valid", 32'(bus.ex_valid), 0);
    check("arst_ex_b", 32'(bus.ex_b), 0);
    check("arst_ex_opcode", 32'(bus.ex_opcode), 0);
    check("arst_ex_rd", 32'(bus.ex_rd), 0);
    check("arst_busy", 32'(dut.busy), 0);
    @(posedge clk);
    #1;
    rst_n        = 1'b1;
    bus.ex_ready = 1'b1;

    // Registers were cleared: ADD r3 = r1 + r2 reads zeros, no stall.
    issue(16'h0642, 1, 8'd0, 8'd0, 4'd0, 3'd3, w);
    check("post_rst_no_stall", 32'(w), 0);
    repeat (3) @(posedge clk);
    #1;
    check("queue_drained", 32'(exp_q.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/id_stage.md
Name: id_stage

Overview:
- Decode stage between instruction fetch and the execute-stage ALU.
- Accepts 16-bit instructions from fetch over a valid/ready handshake, decodes them, and reads operands from an 8-entry register file.
- Blocks read-after-write and write-after-write hazards with a per-register busy scoreboard.
- Delivers registered operands and an ALU opcode to EX; accepts writebacks from the downstream WB stage.

Parameters:
- WIDTH, 8, data/register width; must be at least 5 so a zero-extended imm5 fits.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- if_valid  in  1  fetch presents an instruction
- if_instr  in  16  instruction word
- if_ready  out  1  decode accepts if_instr this cycle
- ex_valid  out  1  EX payload valid
- ex_ready  in  1  EX accepts the payload
- ex_a  out  WIDTH  operand A (rs1 value)
- ex_b  out  WIDTH  operand B (rs2 value or zero-extended imm5)
- ex_opcode  out  4  ALU opcode, 0..7
- ex_rd  out  3  destination register
- wb_en  in  1  writeback strobe
- wb_rd  in  3  writeback register
- wb_data  in  WIDTH  writeback data
- illegal  out  1  one-cycle pulse when an illegal opcode is consumed

Behaviour:
- Reset (async, rst_n=0): ex_valid=0; ex_a, ex_b, ex_opcode, ex_rd = 0; illegal=0; all registers = 0; all busy bits = 0.
- Instruction fields:
  - [15:12] opcode
  - [11:9] rd
  - [8:6] rs1
  - [5] use_imm
  - [4:0] imm5 when use_imm=1; otherwise rs2 is [2:0] and [4:3] are ignored.
- Legal opcodes are 0..7. Opcodes 8..15 are illegal.
- R0:
  - always reads 0;
  - writes to R0 are ignored;
  - its busy bit is never set.
- Hazard (combinational, legal instructions only): busy[rs1], or busy[rs2] when use_imm=0, or busy[rd]. A busy bit being cleared by a writeback in the same cycle counts as not busy.
- Ready and transfer:
  - if_ready = (!ex_valid || ex_ready) && !hazard.
  - Transfer occurs on if_valid && if_ready.
- Legal transfer:
  - Output registers load at the next edge and ex_valid=1 (1-cycle latency).
  - busy[rd] is set when rd != 0.
- Illegal transfer:
  - The instruction is consumed; nothing is issued.
  - illegal=1 for exactly one cycle.
  - ex_valid clears if ex_ready was high, otherwise it holds. No scoreboard change.
- Holding the payload: ex_valid && !ex_ready keeps ex_* stable and if_ready low.
- Draining: ex_ready with no new transfer sets ex_valid=0.
- Writeback, when wb_en && wb_rd != 0:
  - the register file is written and busy[wb_rd] is cleared at the edge.
- Write-first bypass: an operand read whose register equals an active wb_rd this cycle returns wb_data.
- Writeback and issue to the same rd in one cycle: the clear is applied first and the set second, so the busy bit ends at 1. This is only reachable when the hazard check passed via the same-cycle clear.
- Reset mid-operation discards any in-flight payload and scoreboard state; it is not required to be glitch-free with respect to the handshake.
- Operand B with use_imm=1 is {WIDTH-5 zeros, imm5}.

Decomposition:
- Package id_pkg holds:
  - ALU opcode constants: ADD=0, SUB=1, AND=2, OR=3, XOR=4, SLT=5, SHL=6, SHR=7;
  - instruction field bit positions;
  - REG_ADDR_W=3 and NUM_REGS=8.
- One sub-module, id_regfile: 8xWIDTH, two async read ports, one sync write port, R0 hardwired to zero, write-first bypass.
- Scoreboard, handshake and output register stay in id_stage.

Test Plan:
- Reset, then write R1=5 and R2=3 via wb, then issue ADD rd=3, rs1=1, rs2=2 with ex_ready=1 -> next cycle ex_valid=1, ex_a=5, ex_b=3, ex_opcode=0, ex_rd=3, and busy[3]=1.
- Issue ADD R3 (R3 busy), then SUB rd=4, rs1=3, rs2=1 -> if_ready=0 until wb_en with wb_rd=3, wb_data=8. In that wb cycle if_ready=1, and next cycle ex_a=8, ex_b=5.
- Hold ex_ready=0 for 3 cycles with ex_valid=1 -> ex_* unchanged and if_ready=0; raising ex_ready admits the next instruction in the same cycle.
- Issue opcode 4'hA -> if_ready=1, illegal pulses for 1 cycle, ex_valid stays 0, and no busy bit changes.
- Issue XOR rd=0, rs1=0, use_imm=1, imm5=5'h1F -> ex_a=0, ex_b=8'h1F, ex_rd=0; no busy bit is set and a following instruction reading R0 does not stall.
- Assert rst_n=0 asynchronously while ex_valid=1 and busy[2]=1 -> ex_valid=0, busy all 0, and registers 0 before the next clock edge.
